// File: rtl/input_debounce_edge.sv
// Board-input conditioner: two-flop synchroniser plus a per-bit stable-time
// debounce FSM for every push-button and slide switch, with registered
// rise/fall pulses per button and a single change pulse for the switch bank.
module input_debounce_edge #(
   parameter int N_BTN     = 5,
   parameter int N_SW      = 16,
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_BTN-1:0] btn_i,
   input  logic [N_SW-1:0]  sw_i,
   output logic [N_BTN-1:0] btn_o,
   output logic [N_BTN-1:0] btn_rise_o,
   output logic [N_BTN-1:0] btn_fall_o,
   output logic [N_SW-1:0]  sw_o,
   output logic             sw_chg_o
);

   // Buttons occupy the low bits and switches the high bits of one combined
   // vector, so every input runs through identical debounce logic.
   localparam int TOT = N_BTN + N_SW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic {
      ST_STABLE,
      ST_COUNTING
   } db_state_t;

   logic [TOT-1:0]   raw;
   logic [TOT-1:0]   sync_s1;
   logic [TOT-1:0]   sync_s2;
   logic [TOT-1:0]   out_q;
   logic [TOT-1:0]   out_d;
   logic [TOT-1:0]   upd;
   db_state_t        state_q [TOT];
   db_state_t        state_d [TOT];
   logic [CNT_W-1:0] cnt_q   [TOT];
   logic [CNT_W-1:0] cnt_d   [TOT];
   logic [N_BTN-1:0] rise_q;
   logic [N_BTN-1:0] fall_q;
   logic             chg_q;

   assign raw = {sw_i, btn_i};

   // Two-flop synchroniser; only the second stage is used downstream.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= raw;
         sync_s2 <= sync_s1;
      end
   end

   // Per-bit state, counter and debounced level registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < TOT; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
         out_q <= '0;
      end else begin
         for (int i = 0; i < TOT; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         out_q <= out_d;
      end
   end

   // Next-state logic: a bit only takes the new level after it has differed
   // from the current output for DB_CYCLES consecutive samples; any sample
   // matching the output again abandons the partial count.
   always_comb begin
      out_d = out_q;
      upd   = '0;
      for (int i = 0; i < TOT; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_STABLE: begin
               if (sync_s2[i] != out_q[i]) begin
                  if (DB_CYCLES == 1) begin
                     out_d[i] = sync_s2[i];
                     upd[i]   = 1'b1;
                  end else begin
                     cnt_d[i]   = CNT_W'(1);
                     state_d[i] = ST_COUNTING;
                  end
               end
            end
            ST_COUNTING: begin
               if (sync_s2[i] == out_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  out_d[i]   = sync_s2[i];
                  upd[i]     = 1'b1;
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = ST_STABLE;
            end
         endcase
      end
   end

   // Edge pulses registered on the same edge as the level update they report.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rise_q <= '0;
         fall_q <= '0;
         chg_q  <= 1'b0;
      end else begin
         rise_q <= upd[N_BTN-1:0] & out_d[N_BTN-1:0];
         fall_q <= upd[N_BTN-1:0] & ~out_d[N_BTN-1:0];
         chg_q  <= |upd[TOT-1:N_BTN];
      end
   end

   assign btn_o      = out_q[N_BTN-1:0];
   assign sw_o       = out_q[TOT-1:N_BTN];
   assign btn_rise_o = rise_q;
   assign btn_fall_o = fall_q;
   assign sw_chg_o   = chg_q;

endmodule
